// File: rtl/instr_encoder.sv
// RV32I instruction word assembler with a one-deep registered output stage and auto-incrementing byte address.
// Optional build macro ENC_RANGE_CHECK_EN: flag immediates that do not fit their format as encode errors.
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        op,
  input  logic [2:0]        f3,
  input  logic              f7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W+1:0] out_addr,
  output logic              full,
  output logic              err
);

  localparam logic [31:0]       NOP       = 32'h0000_0013;
  localparam logic [ADDR_W+1:0] BASE      = BASE_ADDR[ADDR_W+1:0];
  localparam logic [ADDR_W+1:0] WORD_STEP = (ADDR_W+2)'(4);

  logic [31:0]       enc;
  logic              enc_err;
  logic [31:0]       word;
  logic [ADDR_W-1:0] word_cnt;
  logic              accept;
  logic              out_hs;

  assign in_ready = !full && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_comb begin
    enc     = '0;
    enc_err = 1'b0;
    case (fmt)
      3'd0: enc = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, op};
      3'd1: begin
        // Shift-immediate forms carry the arithmetic/logical select in bit 30.
        if (f3 == 3'b101) enc = {imm[11], f7, imm[9:0], rs1, f3, rd, op};
        else              enc = {imm[11:0], rs1, f3, rd, op};
      end
      3'd2: enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3: begin
        enc     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        enc_err = imm[0];
      end
      3'd4: enc = {imm[31:12], rd, op};
      3'd5: begin
        enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        enc_err = imm[0];
      end
      default: enc_err = 1'b1;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (fmt)
      3'd1, 3'd2: if (imm[31:11] != {21{imm[11]}}) enc_err = 1'b1;
      3'd3:       if (imm[31:12] != {20{imm[12]}}) enc_err = 1'b1;
      3'd5:       if (imm[31:20] != {12{imm[20]}}) enc_err = 1'b1;
      default:    ;
    endcase
`endif
  end

  assign word = enc_err ? NOP : enc;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE;
      word_cnt  <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (out_hs) begin
        out_addr <= out_addr + WORD_STEP;
        word_cnt <= word_cnt + 1'b1;
        if (word_cnt == '1) full <= 1'b1;
      end
      if (accept) begin
        out_instr <= word;
        out_valid <= 1'b1;
        if (enc_err) err <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
